// File: rtl/multicycle_controller_if.sv
// Controller <-> multicycle datapath bundle.
// master : controller side (takes IR/flags/address bits, drives selects and strobes)
// slave  : datapath side (mirror of master)
// Instr[31:12] instruction register, ALUFlags NZCV, AddrLo ALU result[1:0],
// PCWrite/AdrSrc/MemWrite/IRWrite/RegWrite/ResultSrc/ALUSrcA/ALUSrcB/ImmSrc/
// RegSrc/ALUControl datapath controls, be byte enables, state_o debug state.
interface multicycle_controller_if #(
  parameter int ALU_W = 2
);
  logic [31:12]      Instr;
  logic [3:0]        ALUFlags;
  logic [1:0]        AddrLo;
  logic              PCWrite;
  logic              AdrSrc;
  logic              MemWrite;
  logic              IRWrite;
  logic              RegWrite;
  logic [1:0]        ResultSrc;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [1:0]        ImmSrc;
  logic [1:0]        RegSrc;
  logic [ALU_W-1:0]  ALUControl;
  logic [3:0]        be;
  logic [3:0]        state_o;

  modport master (
    input  Instr, ALUFlags, AddrLo,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, be, state_o
  );

  modport slave (
    output Instr, ALUFlags, AddrLo,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, be, state_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM controller: Moore FSM sequencing fetch/decode, memory,
// data-processing and branch instructions; holds NZCV and evaluates Cond.
// Ports: clk, reset (sync, active high), bus (multicycle_controller_if.master).
// ALUControl: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR (EOR/CMP only when ALU_W=3).
module multicycle_controller #(
  parameter int ALU_W   = 2,
  parameter int BYTE_EN = 1
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    UNKNOWN = 4'd15
  } state_t;

  localparam logic [ALU_W-1:0] OP_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] OP_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] OP_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] OP_ORR = ALU_W'(3);
  localparam logic [ALU_W-1:0] OP_EOR = ALU_W'(4);

  state_t state, state_nxt;
  logic [3:0] flags;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic i_bit, s_bit, b_bit;
  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign i_bit = bus.Instr[25];
  assign cmd   = bus.Instr[24:21];
  assign b_bit = bus.Instr[22];
  assign s_bit = bus.Instr[20];   // S for data-processing, L for memory

  logic unused_ok;
  assign unused_ok = ^bus.Instr[19:12];

  // Data-processing decode; unsupported commands leave cmd_ok low so the
  // instruction degrades to a no-op.
  logic cmd_ok, cmd_logic, cmd_cmp;
  logic [ALU_W-1:0] alu_dp;
  always_comb begin
    cmd_ok = 1'b1; cmd_logic = 1'b0; cmd_cmp = 1'b0; alu_dp = OP_ADD;
    case (cmd)
      4'b0100: alu_dp = OP_ADD;
      4'b0010: alu_dp = OP_SUB;
      4'b0000: begin alu_dp = OP_AND; cmd_logic = 1'b1; end
      4'b1100: begin alu_dp = OP_ORR; cmd_logic = 1'b1; end
      4'b0001: if (ALU_W == 3) begin alu_dp = OP_EOR; cmd_logic = 1'b1; end
               else cmd_ok = 1'b0;
      4'b1010: if (ALU_W == 3) begin alu_dp = OP_SUB; cmd_cmp = 1'b1; end
               else cmd_ok = 1'b0;
      default: cmd_ok = 1'b0;
    endcase
  end

  // CondEx reads the live flag register, so a conditional flag-setting
  // instruction is re-evaluated against its own new flags in ALUWB.
  logic n, z, c, v, cond_ex;
  assign {n, z, c, v} = flags;
  always_comb begin
    case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic exec, flag_we_nz, flag_we_cv;
  assign exec       = (state == EXECR) || (state == EXECI);
  assign flag_we_nz = exec && s_bit && cond_ex && cmd_ok;
  assign flag_we_cv = flag_we_nz && !cmd_logic;

  always_ff @(posedge clk) begin
    if (reset) flags <= 4'b0000;
    else begin
      if (flag_we_nz) flags[3:2] <= bus.ALUFlags[3:2];
      if (flag_we_cv) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE:
        case (op)
          2'b01:   state_nxt = MEMADR;
          2'b00:   state_nxt = i_bit ? EXECI : EXECR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = UNKNOWN;
        endcase
      MEMADR: state_nxt = s_bit ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXECR, EXECI: state_nxt = ALUWB;
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs
  logic pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] result_src, alu_src_b;
  logic [ALU_W-1:0] alu_ctl;
  logic [3:0] be_r, be_acc;
  assign be_acc = ((BYTE_EN != 0) && b_bit) ? (4'b0001 << bus.AddrLo) : 4'b1111;

  always_comb begin
    pc_write = 1'b0; adr_src = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
    reg_write = 1'b0; alu_src_a = 1'b0; result_src = 2'b00; alu_src_b = 2'b00;
    alu_ctl = OP_ADD; be_r = 4'b1111;
    case (state)
      FETCH:  begin
        ir_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 2'b10;
        result_src = 2'b10; pc_write = 1'b1;
      end
      DECODE: begin alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; end
      MEMADR: alu_src_b = 2'b01;
      MEMRD:  begin adr_src = 1'b1; be_r = be_acc; end
      MEMWB:  begin result_src = 2'b01; reg_write = cond_ex; end
      MEMWR:  begin adr_src = 1'b1; mem_write = cond_ex; be_r = be_acc; end
      EXECR:  alu_ctl = alu_dp;
      EXECI:  begin alu_src_b = 2'b01; alu_ctl = alu_dp; end
      ALUWB:  reg_write = cond_ex && cmd_ok && !cmd_cmp;
      BRANCH: begin alu_src_b = 2'b01; result_src = 2'b10; pc_write = cond_ex; end
      default: ;
    endcase
  end

  // Strobes are squashed combinationally so nothing is written in a reset cycle.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.be         = be_r;
  assign bus.state_o    = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances in lockstep
// (u0: ALU_W=3/BYTE_EN=1, u1: ALU_W=2/BYTE_EN=0) against an
// instruction-level reference model.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:12] instr = '0;
  logic [3:0] alu_flags = '0;
  logic [1:0] addr_lo = '0;
  int n_chk = 0, n_err = 0;

  logic [3:0] flags_m [2];
  int alu_w_m [2] = '{3, 2};
  bit be_en_m [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  multicycle_controller_if #(.ALU_W(3)) ifa ();
  multicycle_controller_if #(.ALU_W(2)) ifb ();
  assign ifa.Instr = instr;  assign ifa.ALUFlags = alu_flags;  assign ifa.AddrLo = addr_lo;
  assign ifb.Instr = instr;  assign ifb.ALUFlags = alu_flags;  assign ifb.AddrLo = addr_lo;

  multicycle_controller #(.ALU_W(3), .BYTE_EN(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  multicycle_controller #(.ALU_W(2), .BYTE_EN(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, memw, irw, regw, srca;
    logic [1:0] rsrc, srcb, imm, rsel;
    logic [2:0] aluc;
    logic [3:0] be;
  } obs_t;
  obs_t obs [2];
  logic [3:0] fl_o [2];
  assign obs[0] = '{ifa.state_o, ifa.PCWrite, ifa.AdrSrc, ifa.MemWrite, ifa.IRWrite,
                    ifa.RegWrite, ifa.ALUSrcA, ifa.ResultSrc, ifa.ALUSrcB, ifa.ImmSrc,
                    ifa.RegSrc, ifa.ALUControl, ifa.be};
  assign obs[1] = '{ifb.state_o, ifb.PCWrite, ifb.AdrSrc, ifb.MemWrite, ifb.IRWrite,
                    ifb.RegWrite, ifb.ALUSrcA, ifb.ResultSrc, ifb.ALUSrcB, ifb.ImmSrc,
                    ifb.RegSrc, {1'b0, ifb.ALUControl}, ifb.be};
  assign fl_o[0] = dut_a.flags;
  assign fl_o[1] = dut_b.flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ARM condition: odd codes invert the even predicate; 1111 never executes.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit fn, fz, fc, fv, base;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (c[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  // 0 unsupported, 1 arithmetic, 2 logical, 3 compare
  function automatic int dp_kind(input logic [3:0] cmd, input int aw);
    case (cmd)
      4'b0100, 4'b0010: return 1;
      4'b0000, 4'b1100: return 2;
      4'b0001: return (aw == 3) ? 2 : 0;
      4'b1010: return (aw == 3) ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int alu_exp(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b0001: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic run_instr(input logic [31:12] ins, input logic [3:0] fl_exec,
                           input logic [1:0] al, input int abort_at);
    int path[$];
    bit ce [2];
    int kind [2];
    logic [1:0] op;
    op = ins[27:26];
    path.push_back(0); path.push_back(1);
    case (op)
      2'b01: begin
        path.push_back(2);
        if (ins[20]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'b00: begin path.push_back(ins[25] ? 7 : 6); path.push_back(8); end
      2'b10: path.push_back(9);
      default: path.push_back(15);
    endcase
    for (int k = 0; k < path.size(); k++) begin
      int st;
      bit ex;
      st = path[k];
      ex = (st == 6) || (st == 7);
      if (k == 1) instr = ins;
      alu_flags = ex ? fl_exec : 4'($urandom);
      addr_lo = al;
      if (k == abort_at) reset = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        string t;
        t = $sformatf("u%0d.i%05h.s%0d", d, ins, st);
        chk({t, ".state"}, obs[d].st, st);
        if (reset) begin
          chk({t, ".rst_pcw"}, obs[d].pcw, 0);
          chk({t, ".rst_memw"}, obs[d].memw, 0);
          chk({t, ".rst_irw"}, obs[d].irw, 0);
          chk({t, ".rst_regw"}, obs[d].regw, 0);
          continue;
        end
        ce[d] = cond_ok(ins[31:28], flags_m[d]);
        kind[d] = dp_kind(ins[24:21], alu_w_m[d]);
        chk({t, ".pcw"}, obs[d].pcw, (k == 0) || (st == 9 && ce[d]));
        chk({t, ".irw"}, obs[d].irw, k == 0);
        chk({t, ".memw"}, obs[d].memw, st == 5 && ce[d]);
        chk({t, ".regw"}, obs[d].regw,
            ce[d] && (st == 4 || (st == 8 && (kind[d] == 1 || kind[d] == 2))));
        chk({t, ".be"}, obs[d].be,
            ((st == 3 || st == 5) && be_en_m[d] && ins[22]) ? (4'b0001 << al) : 4'hF);
        if (k > 0) begin
          chk({t, ".imm"}, obs[d].imm, op);
          chk({t, ".rsel"}, obs[d].rsel, {op == 2'b01, op == 2'b10});
        end
        case (st)
          0: begin
            chk({t, ".adr"}, obs[d].adr, 0);   chk({t, ".srca"}, obs[d].srca, 1);
            chk({t, ".srcb"}, obs[d].srcb, 2); chk({t, ".rsrc"}, obs[d].rsrc, 2);
            chk({t, ".aluc"}, obs[d].aluc, 0);
          end
          1: begin
            chk({t, ".srca"}, obs[d].srca, 1); chk({t, ".srcb"}, obs[d].srcb, 2);
            chk({t, ".rsrc"}, obs[d].rsrc, 2);
          end
          2: begin chk({t, ".srcb"}, obs[d].srcb, 1); chk({t, ".aluc"}, obs[d].aluc, 0); end
          3, 5: chk({t, ".adr"}, obs[d].adr, 1);
          4: chk({t, ".rsrc"}, obs[d].rsrc, 1);
          6, 7: begin
            chk({t, ".srcb"}, obs[d].srcb, (st == 7) ? 1 : 0);
            if (kind[d] != 0) chk({t, ".aluc"}, obs[d].aluc, alu_exp(ins[24:21]));
          end
          8: chk({t, ".rsrc"}, obs[d].rsrc, 0);
          9: begin chk({t, ".srcb"}, obs[d].srcb, 1); chk({t, ".rsrc"}, obs[d].rsrc, 2); end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      if (k == abort_at) begin
        reset = 1'b0;
        flags_m[0] = 4'h0; flags_m[1] = 4'h0;
        chk("abort.flags_u0", fl_o[0], 4'h0);
        chk("abort.flags_u1", fl_o[1], 4'h0);
        return;
      end
      if (ex) begin
        for (int d = 0; d < 2; d++) begin
          if (ins[20] && ce[d] && kind[d] != 0) begin
            if (kind[d] == 2) flags_m[d][3:2] = fl_exec[3:2];
            else flags_m[d] = fl_exec;
          end
        end
      end
    end
    chk($sformatf("i%05h.flags_u0", ins), fl_o[0], flags_m[0]);
    chk($sformatf("i%05h.flags_u1", ins), fl_o[1], flags_m[1]);
  endtask

  initial begin
    flags_m[0] = 4'h0; flags_m[1] = 4'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset.state_u%0d", d), obs[d].st, 0);
      chk($sformatf("reset.pcw_u%0d", d), obs[d].pcw, 0);
      chk($sformatf("reset.irw_u%0d", d), obs[d].irw, 0);
      chk($sformatf("reset.flags_u%0d", d), fl_o[d], 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(20'hE2921, 4'b0100, 2'd0, -1);  // ADDS R1,R2,#1
    run_instr(20'h0A000, 4'b0000, 2'd0, -1);  // BEQ taken (Z=1)
    run_instr(20'h15812, 4'b0000, 2'd1, -1);  // STRNE with Z=1: suppressed
    run_instr(20'hE5D12, 4'b0000, 2'd2, -1);  // LDRB, AddrLo=10
    run_instr(20'hE1512, 4'b1001, 2'd0, -1);  // CMP (ALU_W=3 only)
    run_instr(20'hE0312, 4'b0110, 2'd0, -1);  // EORS (ALU_W=3 only)
    run_instr(20'hE2921, 4'b0000, 2'd0, -1);  // ADDS clearing Z
    run_instr(20'h0A000, 4'b0000, 2'd0, -1);  // BEQ not taken
    run_instr(20'hE2921, 4'b1111, 2'd0, -1);  // ADDS setting all flags
    run_instr(20'hE5812, 4'b0000, 2'd3, 3);   // STR aborted by reset in MEMWR
    run_instr(20'hEC000, 4'b0000, 2'd0, -1);  // op 11: no-op
    run_instr(20'hE5C12, 4'b0000, 2'd3, -1);  // STRB, AddrLo=11

    for (int i = 0; i < 200; i++)
      run_instr(20'($urandom), 4'($urandom), 2'($urandom), -1);

    @(negedge clk);
    chk("end.state_u0", obs[0].st, 0);
    chk("end.state_u1", obs[1].st, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle ARM controller.
- Sequences each instruction through a Moore FSM:
  - fetch and decode;
  - ALU operations, loads and stores;
  - branches.
- Holds the NZCV flags and evaluates the condition field.
- Generates byte enables for word and byte accesses.
- Sits beside the multicycle datapath. It drives all mux selects and write strobes from the instruction register and the ALU flags.

Parameters:
- ALU_W, 2, ALUControl width. Legal values are 2 or 3.
  - With 2: ADD, SUB, AND, ORR.
  - With 3: adds EOR (cmd 0001) and CMP (cmd 1010).
- BYTE_EN, 1, when 1, Instr[22] selects LDRB/STRB. When 0, byte accesses are treated as word accesses.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Instr  input  20 [31:12]  instruction register contents
- ALUFlags  input  4  NZCV from the ALU in the current cycle
- AddrLo  input  2  address bits [1:0] from the ALU result, used for byte lane selection
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register enable
- RegWrite  output  1  register file write
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  1  ALU A select: 0 = register, 1 = PC
- ALUSrcB  output  2  ALU B select: 00 = register, 01 = ExtImm, 10 = constant 4
- ImmSrc  output  2  equals Instr[27:26]
- RegSrc  output  2  register address selects, as in the single-cycle controller
- ALUControl  output  ALU_W  ALU operation
- be  output  4  byte enables
- state_o  output  4  current FSM state, for debug

Behaviour:
- Reset: on the next rising clk edge the state becomes FETCH and Flags becomes 0000. While reset is high, the strobes (PCWrite, MemWrite, RegWrite, IRWrite) are forced to 0.
- Reset asserted in the middle of an instruction aborts it. No write strobe may assert in the reset cycle.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, UNKNOWN 15.
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. PCWrite here is unconditional.
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This computes PC+8.
  - Next state by Op = Instr[27:26]:
    - 01 → MEMADR.
    - 00 with Instr[25]=1 → EXECI.
    - 00 with Instr[25]=0 → EXECR.
    - 10 → BRANCH.
    - 11 → UNKNOWN.
- MEMADR:
  - Outputs: ALUSrcB=01, ALUControl=ADD.
  - Next state: MEMRD if L (Instr[20]) = 1, else MEMWR.
- MEMRD: AdrSrc=1; next state MEMWB.
- MEMWB: ResultSrc=01; RegWrite = CondEx; next state FETCH.
- MEMWR: AdrSrc=1; MemWrite = CondEx; next state FETCH.
- EXECR / EXECI:
  - ALUSrcB = 00 for EXECR, 01 for EXECI. ALUControl is decoded from cmd = Instr[24:21].
  - Next state: ALUWB.
  - Flags update at the end of this cycle when S = Instr[20] is 1 and CondEx is 1:
    - Logical ops write N and Z only.
    - ADD, SUB and CMP write all four flags.
- ALUWB: ResultSrc=00; RegWrite = CondEx, except that CMP never writes; next state FETCH.
- BRANCH:
  - Outputs: ALUSrcB=01, ResultSrc=10, PCWrite = CondEx.
  - Next state: FETCH.
- UNKNOWN:
  - All strobes are 0; next state FETCH. The instruction is a no-op.
- An unsupported cmd under the current ALU_W behaves as a no-op: no RegWrite and no flag write.
- CondEx is combinational from Cond = Instr[31:28] and the registered Flags, using the standard ARM table (EQ through AL). Cond 1111 gives CondEx = 0.
- be:
  - Word access: be = 1111.
  - Byte access (BYTE_EN=1 and Instr[22]=1): be = 0001 << AddrLo.
  - be is only meaningful during MEMRD and MEMWR. Elsewhere it is 1111.
- Latency in cycles:
  - Branch: 3.
  - Data-processing: 4.
  - STR: 4.
  - LDR: 5.
- A failed condition still spends the full cycle count with all writes suppressed. The PC increment from FETCH still occurs.

Test Plan:
- Reset mid-MEMWR (state 5, Cond=AL): assert reset → MemWrite=0 that cycle; next cycle state_o=0 and Flags=0000.
- ADDS R1,R2,#1, Instr=0xE29 with ALUFlags=0100 in EXECI → states 0,1,7,8; Flags=0100; RegWrite=1 only in ALUWB.
- BEQ taken and not taken:
  - With Z=1: PCWrite=1 in BRANCH.
  - With Z=0: PCWrite=0 in BRANCH and exactly 3 cycles.
- LDRB with AddrLo=10, BYTE_EN=1 → be=0100 in MEMRD; states 0,1,2,3,4; RegWrite in MEMWB.
- STR with Cond=NE, Z=1 → MemWrite stays 0; state returns to FETCH after 4 cycles.
- ALU_W=3, CMP cmd 1010 with S=1 → ALUControl=SUB; Flags updated; RegWrite=0 in ALUWB. With ALU_W=2, EOR cmd 0001 → no RegWrite and no flag change.
